wb_pwm_capture: RTL and testbench
=================================

# wb_pwm_capture

Wishbone-slave PWM input-capture peripheral: the receiving counterpart to the team's PWM generator. Each channel synchronises an external PWM pin and measures period and high time in clock cycles. Results, per-channel enables and sticky valid/overflow flags are exposed as 32-bit registers on the same Wishbone bus as the other peripherals.

## Interface
- CAP_PORT_CNT, default 4: number of capture channels, legal range 1..8 (elaboration-time `$fatal` otherwise).
- wb.clk_i  in  1: sole clock (member of the `wishbone_p_if.slave` port `wb`).
- wb.rst_i  in  1: reset, synchronous and active-high.
- wb  slave  -: Wishbone pipelined slave carrying cyc, stb, we, adr, dat_i[31:0], dat_o[31:0], ack, stall.
- pwm_in_ports  in  CAP_PORT_CNT: asynchronous PWM inputs, one per channel.

## Operation
- Register map (word index = adr[5:2]):
  - 0 CTRL: rw; [CAP_PORT_CNT-1:0] channel enable.
  - 1 STATUS: [7:0] valid, [15:8] overflow; both sticky and write-1-to-clear.
  - 2+i RESULT_i: ro; [31:16] period, [15:0] high time.
- Unused bits and unmapped indices read 0. Writes to RESULT or unmapped indices are ignored.
- Per channel, always running even when disabled:
  - 2-flop synchroniser s1→s, then delay flop s_d.
  - rise = s & !s_d; fall = !s & s_d.
- Per-channel state while enabled: armed flag, cnt[15:0], hi_tmp[15:0].
- Channel FSM:
  - IDLE (disabled): cnt, hi_tmp and armed held at 0. Go to WAIT when the enable bit is 1.
  - WAIT (enabled, !armed): on rise → armed=1, cnt<=1, hi_tmp<=0 (MEASURE). No capture.
  - MEASURE (armed): cnt increments each cycle. On fall, hi_tmp<=cnt.
    - On rise with cnt<0xFFFF: RESULT_i<={cnt, hi_tmp}, valid[i] set, cnt<=1, remain MEASURE.
    - When cnt==0xFFFF (takes precedence over a rise in the same cycle): overflow[i] set, armed cleared → WAIT. RESULT_i is unchanged.
- Arithmetic: for rises at cycles t0, t1, period = t1−t0. High time = (fall cycle)−t0. Maximum measurable period is 65534.
- Clearing the enable bit mid-measurement returns the channel to IDLE next cycle. RESULT_i and STATUS are retained.
- Re-enabling always requires a fresh arming rise.
- Constant-level input: no capture. Overflow fires only if the channel is armed.
- Same-cycle conflicts:
  - Hardware set of a STATUS bit and W1C of that bit in the same cycle → bit ends set.
  - CTRL write takes effect in the following cycle.
- Reset state: CTRL=0, STATUS=0, all RESULT=0, synchronisers=0, all channels IDLE.

## Timing
- stall = 0 always.
- ack = cyc & stb, combinational and zero-wait, for reads and writes to any address.
- dat_o is combinational from the registers when cyc & stb & !we, else 32'h0.
- Register writes commit on the clock edge where cyc & stb & we.
- Input-to-result latency:
  - A pin rise first sampled at clock edge k appears in s after edge k+1.
  - rise is asserted in the cycle after edge k+1.
  - RESULT_i and valid[i] update at edge k+2 and are readable in the cycle after.
- Output reset values: ack=0 and dat_o=0 whenever cyc/stb are low, including during reset.

## Test plan
- Reset: assert wb.rst_i 2 cycles, read indices 0–3 and 9 → all 0x0000_0000. ack equals cyc & stb with 0 wait states.
- 25% duty capture:
  - Stimulus: CTRL=0x1; drive ch0 high 25 cycles / low 75 cycles for 3 periods.
  - Before the second rise is captured → STATUS=0.
  - After the second rise → RESULT_0=0x0064_0019, STATUS=0x0000_0001.
  - Write STATUS=0x1 → reads 0; the next capture sets it again.
- Overflow: CTRL=0x4, single rise on ch2, then hold low → exactly 65535 cycles after arming STATUS[10]=1, RESULT_2 unchanged, no valid.
  - Next two rises 500 apart → RESULT_2[31:16]=0x01F4.
- Disable mid-measure: ch1 armed, clear CTRL bit 1 mid-period → RESULT_1 and STATUS unchanged.
  - Re-enable: the first rise only arms; the second rise captures.
- Set/clear collision: a W1C of valid[0] landing on the capture edge → valid[0] reads 1 afterwards.
- Bus hygiene:
  - Write 0xFFFF_FFFF to RESULT_0 and to index 12 → no state change; index 12 reads 0.
  - CTRL reads back only [CAP_PORT_CNT-1:0].

Source files
------------

// File: rtl/wb_pwm_capture_if.sv
// Pipelined Wishbone bus bundle shared by the peripherals.
// The clock and reset travel with the bus.
interface wishbone_p_if (
    input logic clk_i,
    input logic rst_i
);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack;
    logic        stall;

    modport master (
        input  clk_i, rst_i, dat_o, ack, stall,
        output cyc, stb, we, adr, dat_i
    );

    modport slave (
        input  clk_i, rst_i, cyc, stb, we, adr, dat_i,
        output dat_o, ack, stall
    );
endinterface

// File: rtl/wb_pwm_capture.sv
// PWM input capture: per-channel period and high-time measurement,
// with results and sticky flags exposed as Wishbone registers.
module wb_pwm_capture #(
    parameter int CAP_PORT_CNT = 4
) (
    wishbone_p_if.slave              wb,
    input  logic [CAP_PORT_CNT-1:0] pwm_in_ports
);
    localparam int N = CAP_PORT_CNT;

    if (N < 1 || N > 8) begin : g_bad_cnt
        $fatal(1, "CAP_PORT_CNT must be in 1..8");
    end

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        MEAS
    } state_t;

    logic clk;
    logic rst;
    assign clk = wb.clk_i;
    assign rst = wb.rst_i;

    logic                 hit;
    logic                 wr;
    logic [3:0]           idx;
    logic [N-1:0]         ctrl;
    logic [N-1:0]         valid;
    logic [N-1:0]         ovf;
    logic [N-1:0]         v_set;
    logic [N-1:0]         o_set;
    logic [N-1:0]         v_clr;
    logic [N-1:0]         o_clr;
    logic [N-1:0][31:0]   res_all;
    logic [31:0]          rdata;

    assign hit      = wb.cyc & wb.stb;
    assign wr       = hit & wb.we;
    assign idx      = wb.adr[5:2];
    assign wb.ack   = hit;
    assign wb.stall = 1'b0;
    assign wb.dat_o = rdata;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic        s1;
        logic        s;
        logic        s_d;
        logic        rise;
        logic        fall;
        logic        en;
        logic        cap;
        logic        ovf_hit;
        logic [15:0] cnt;
        logic [15:0] hi;
        logic [15:0] cnt_nxt;
        logic [15:0] hi_nxt;
        logic [31:0] result;
        state_t      st;
        state_t      st_nxt;

        // Synchroniser keeps running while disabled so re-enable sees clean edges.
        always_ff @(posedge clk) begin
            if (rst) begin
                s1  <= 1'b0;
                s   <= 1'b0;
                s_d <= 1'b0;
            end else begin
                s1  <= pwm_in_ports[i];
                s   <= s1;
                s_d <= s;
            end
        end

        assign rise    = s & ~s_d;
        assign fall    = ~s & s_d;
        assign en      = ctrl[i];
        assign ovf_hit = (cnt == 16'hFFFF);

        always_ff @(posedge clk) begin
            if (rst) begin
                st  <= IDLE;
                cnt <= '0;
                hi  <= '0;
            end else begin
                st  <= st_nxt;
                cnt <= cnt_nxt;
                hi  <= hi_nxt;
            end
        end

        always_comb begin
            st_nxt = st;
            unique case (st)
                IDLE: st_nxt = en ? WAIT : IDLE;
                WAIT: begin
                    if (!en)       st_nxt = IDLE;
                    else if (rise) st_nxt = MEAS;
                end
                MEAS: begin
                    if (!en)          st_nxt = IDLE;
                    else if (ovf_hit) st_nxt = WAIT;
                end
                default: st_nxt = IDLE;
            endcase
        end

        always_comb begin
            cnt_nxt = cnt;
            hi_nxt  = hi;
            cap     = 1'b0;
            o_set[i] = 1'b0;
            unique case (st)
                WAIT: begin
                    if (!en || rise) begin
                        cnt_nxt = {15'd0, en};
                        hi_nxt  = '0;
                    end
                end
                MEAS: begin
                    if (!en) begin
                        cnt_nxt = '0;
                        hi_nxt  = '0;
                    end else if (ovf_hit) begin
                        o_set[i] = 1'b1;
                        cnt_nxt  = '0;
                        hi_nxt   = '0;
                    end else if (rise) begin
                        cap     = 1'b1;
                        cnt_nxt = 16'd1;
                    end else begin
                        cnt_nxt = cnt + 16'd1;
                        if (fall) hi_nxt = cnt;
                    end
                end
                default: begin
                    cnt_nxt = '0;
                    hi_nxt  = '0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst)      result <= '0;
            else if (cap) result <= {cnt, hi};
        end

        assign v_set[i]   = cap;
        assign res_all[i] = result;
    end

    assign v_clr = (wr && idx == 4'd1) ? wb.dat_i[N-1:0]   : '0;
    assign o_clr = (wr && idx == 4'd1) ? wb.dat_i[8 +: N]  : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl  <= '0;
            valid <= '0;
            ovf   <= '0;
        end else begin
            if (wr && idx == 4'd0) ctrl <= wb.dat_i[N-1:0];
            // Hardware set wins over a same-cycle clear.
            valid <= (valid & ~v_clr) | v_set;
            ovf   <= (ovf & ~o_clr) | o_set;
        end
    end

    always_comb begin
        rdata = '0;
        if (hit && !wb.we) begin
            unique case (1'b1)
                (idx == 4'd0): rdata[N-1:0] = ctrl;
                (idx == 4'd1): begin
                    rdata[N-1:0]  = valid;
                    rdata[8 +: N] = ovf;
                end
                default: begin
                    for (int i = 0; i < N; i++) begin
                        if (idx == 4'(i + 2)) rdata = res_all[i];
                    end
                end
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{wb.dat_i, wb.adr};
endmodule

// File: tb/tb_wb_pwm_capture.sv
// Bench for wb_pwm_capture: timestamp-based reference model checked
// every cycle, plus directed reads with literal expectations.
module tb_wb_pwm_capture;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] pins = '0;

    always #5 clk = ~clk;

    wishbone_p_if bus (.clk_i(clk), .rst_i(rst));

    wb_pwm_capture #(.CAP_PORT_CNT(N)) dut (
        .wb           (bus),
        .pwm_in_ports (pins)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: events are timestamps on a free-running edge count.
    longint       now = 0;
    bit           model_ok = 0;
    logic [N-1:0] h1, h2, h3;
    logic [N-1:0] m_ctrl, m_valid, m_ovf, m_idle, m_armed;
    longint       m_t0 [N];
    logic [15:0]  m_hi [N];
    logic [31:0]  m_res [N];

    function automatic logic [31:0] mread(input logic [3:0] i);
        logic [31:0] v;
        v = '0;
        if (i == 4'd0) v[N-1:0] = m_ctrl;
        else if (i == 4'd1) begin
            v[N-1:0]  = m_valid;
            v[8 +: N] = m_ovf;
        end else if (i >= 4'd2 && int'(i) < N + 2) v = m_res[int'(i) - 2];
        return v;
    endfunction

    always @(posedge clk) begin
        logic [N-1:0] vs, os, vc, oc;
        now++;
        if (rst) begin
            h1 = '0; h2 = '0; h3 = '0;
            m_ctrl = '0; m_valid = '0; m_ovf = '0;
            m_idle = '1; m_armed = '0;
            for (int i = 0; i < N; i++) begin
                m_t0[i] = 0; m_hi[i] = '0; m_res[i] = '0;
            end
            model_ok = 1;
        end else begin
            vs = '0; os = '0; vc = '0; oc = '0;
            for (int i = 0; i < N; i++) begin
                bit r, f;
                r = h2[i] & ~h3[i];
                f = ~h2[i] & h3[i];
                if (!m_ctrl[i]) begin
                    m_idle[i] = 1; m_armed[i] = 0;
                end else if (m_idle[i]) begin
                    m_idle[i] = 0;
                end else if (!m_armed[i]) begin
                    if (r) begin
                        m_armed[i] = 1; m_t0[i] = now; m_hi[i] = '0;
                    end
                end else if (now - m_t0[i] == 65535) begin
                    os[i] = 1; m_armed[i] = 0;
                end else if (r) begin
                    m_res[i] = {16'(now - m_t0[i]), m_hi[i]};
                    vs[i] = 1; m_t0[i] = now;
                end else if (f) begin
                    m_hi[i] = 16'(now - m_t0[i]);
                end
            end
            if (bus.cyc && bus.stb && bus.we && bus.adr[5:2] == 4'd1) begin
                vc = bus.dat_i[N-1:0];
                oc = bus.dat_i[8 +: N];
            end
            m_valid = (m_valid & ~vc) | vs;
            m_ovf   = (m_ovf & ~oc) | os;
            if (bus.cyc && bus.stb && bus.we && bus.adr[5:2] == 4'd0)
                m_ctrl = bus.dat_i[N-1:0];
            h3 = h2; h2 = h1; h1 = pins;
        end
    end

    always @(negedge clk) begin
        logic        ea;
        logic [31:0] ed;
        if (model_ok) begin
            ea = bus.cyc & bus.stb;
            ed = (ea && !bus.we) ? mread(bus.adr[5:2]) : 32'h0;
            n_vec++;
            if (bus.ack !== ea || bus.dat_o !== ed) begin
                n_err++;
                $display("FAIL model t=%0t ack=%b/%b dat_o=%h required %h",
                         $time, bus.ack, ea, bus.dat_o, ed);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wr(input logic [3:0] i, input logic [31:0] d);
        bus.cyc = 1; bus.stb = 1; bus.we = 1;
        bus.adr = {26'd0, i, 2'b00}; bus.dat_i = d;
        tick(1);
        bus.cyc = 0; bus.stb = 0; bus.we = 0; bus.dat_i = '0;
    endtask

    task automatic rd(input string nm, input logic [3:0] i, input logic [31:0] exp);
        bus.cyc = 1; bus.stb = 1; bus.we = 0;
        bus.adr = {26'd0, i, 2'b00};
        @(negedge clk);
        n_vec++;
        if (bus.dat_o !== exp || bus.ack !== 1'b1) begin
            n_err++;
            $display("FAIL %s idx=%0d got %h ack=%b required %h", nm, i, bus.dat_o, bus.ack, exp);
        end
        tick(1);
        bus.cyc = 0; bus.stb = 0;
    endtask

    initial begin
        bus.cyc = 0; bus.stb = 0; bus.we = 0;
        bus.adr = '0; bus.dat_i = '0;
        tick(2);
        rst = 0;
        tick(1);
        rd("rst_ctrl", 0, 32'h0);
        rd("rst_status", 1, 32'h0);
        rd("rst_res0", 2, 32'h0);
        rd("rst_res1", 3, 32'h0);
        rd("rst_idx9", 9, 32'h0);

        // 25% duty on ch0, period 100
        wr(0, 32'h1);
        tick(2);
        for (int c = 0; c < 330; c++) begin
            pins[0] = (c % 100) < 25;
            case (c)
                50:  rd("arm_only", 2, 32'h0);
                102: rd("pre_cap", 1, 32'h0);
                103: rd("duty_res", 2, 32'h0064_0019);
                104: rd("duty_valid", 1, 32'h1);
                105: wr(1, 32'h1);
                106: rd("w1c", 1, 32'h0);
                203: rd("reset_valid", 1, 32'h1);
                302: wr(1, 32'h1);
                304: rd("collision", 1, 32'h1);
                305: rd("duty_res2", 2, 32'h0064_0019);
                default: tick(1);
            endcase
        end
        pins[0] = 0;
        wr(0, 32'h0);
        wr(1, 32'hFFFF_FFFF);
        rd("clr_all", 1, 32'h0);

        // Overflow on ch2, then a 500-cycle period
        wr(0, 32'h4);
        tick(2);
        for (int c = 0; c < 66111; c++) begin
            pins[2] = (c < 10) || (c >= 65600 && c < 65610) || (c >= 66100 && c < 66110);
            case (c)
                65536: rd("pre_ovf", 1, 32'h0);
                65537: rd("pre_ovf2", 1, 32'h0);
                65538: rd("ovf", 1, 32'h0000_0400);
                65539: rd("ovf_res", 4, 32'h0);
                66103: rd("res2", 4, 32'h01F4_000A);
                66104: rd("res2_st", 1, 32'h0000_0404);
                default: tick(1);
            endcase
        end
        pins[2] = 0;
        wr(0, 32'h0);
        wr(1, 32'hFFFF_FFFF);

        // Disable mid-measure on ch1, then re-enable
        wr(0, 32'h2);
        tick(2);
        for (int c = 0; c < 300; c++) begin
            pins[1] = (c < 30) || (c >= 100 && c < 130) ||
                      (c >= 150 && c < 180) || (c >= 250 && c < 280);
            case (c)
                50:  wr(0, 32'h0);
                60:  rd("dis_st", 1, 32'h0);
                61:  rd("dis_res", 3, 32'h0);
                120: wr(0, 32'h2);
                240: rd("rearm", 3, 32'h0);
                253: rd("recap", 3, 32'h0064_001E);
                254: rd("recap_st", 1, 32'h2);
                default: tick(1);
            endcase
        end
        pins[1] = 0;

        // Bus hygiene
        wr(2, 32'hFFFF_FFFF);
        wr(12, 32'hFFFF_FFFF);
        rd("idx12", 12, 32'h0);
        rd("ro_res0", 2, 32'h0064_0019);
        rd("ro_res1", 3, 32'h0064_001E);
        wr(0, 32'hFFFF_FFFF);
        rd("ctrl_mask", 0, 32'h0000_000F);
        rd("hyg_st", 1, 32'h2);
        rd("idx9", 9, 32'h0);
        wr(0, 32'h0);
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
